// File: rtl/line_draw_controller.sv
// Line draw controller: sequences an external one-pixel-per-clock Bresenham
// drawer for single line commands and for a row-by-row full-screen clear,
// and turns the drawer's position into a framebuffer write stream.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          line command handshake
//   cmd_x0/x1, cmd_y0/y1         line endpoints
//   cmd_color                    line color
//   clear_req                    level request for a full-screen clear
//   busy, done                   controller active / one-cycle completion pulse
//   drv_reset                    drawer synchronous reset (high parks the drawer)
//   drv_x0/x1, drv_y0/y1         drawer endpoints
//   drv_x, drv_y                 drawer current pixel
//   pix_x, pix_y, pix_color      framebuffer write address and data
//   pix_we                       framebuffer write enable
module line_draw_controller #(
  parameter int unsigned         SCREEN_W    = 640,
  parameter int unsigned         SCREEN_H    = 480,
  parameter int unsigned         COLOR_W     = 1,
  parameter logic [COLOR_W-1:0]  CLEAR_COLOR = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_x0,
  input  logic [9:0]         cmd_x1,
  input  logic [8:0]         cmd_y0,
  input  logic [8:0]         cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               clear_req,
  output logic               busy,
  output logic               done,
  output logic               drv_reset,
  output logic [9:0]         drv_x0,
  output logic [9:0]         drv_x1,
  output logic [8:0]         drv_y0,
  output logic [8:0]         drv_y1,
  input  logic [9:0]         drv_x,
  input  logic [8:0]         drv_y,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_we
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_DRAW     = 3'd2;
  localparam logic [2:0] S_NEXT_ROW = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);

  logic [2:0]         r_state, w_state;
  logic [9:0]         r_x0, r_x1, w_x0, w_x1;
  logic [8:0]         r_y0, r_y1, w_y0, w_y1;
  logic [COLOR_W-1:0] r_color, w_color;
  logic [10:0]        r_count, w_count;
  logic [8:0]         r_row, w_row;
  logic               r_clear, w_clear;
  logic [10:0]        w_dx, w_dy;

  // Absolute endpoint deltas; pixel count is the larger one plus one.
  assign w_dx = (r_x1 >= r_x0) ? 11'(r_x1 - r_x0) : 11'(r_x0 - r_x1);
  assign w_dy = (r_y1 >= r_y0) ? 11'(r_y1 - r_y0) : 11'(r_y0 - r_y1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
      r_count <= '0;
      r_row   <= '0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x0    <= w_x0;
      r_x1    <= w_x1;
      r_y0    <= w_y0;
      r_y1    <= w_y1;
      r_color <= w_color;
      r_count <= w_count;
      r_row   <= w_row;
      r_clear <= w_clear;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state = r_state;
    w_x0    = r_x0;
    w_x1    = r_x1;
    w_y0    = r_y0;
    w_y1    = r_y1;
    w_color = r_color;
    w_count = r_count;
    w_row   = r_row;
    w_clear = r_clear;
    case (r_state)
      S_IDLE: begin
        // A pending clear has priority over any command.
        if (clear_req) begin
          w_clear = 1'b1;
          w_row   = '0;
          w_x0    = '0;
          w_y0    = '0;
          w_x1    = X_MAX;
          w_y1    = '0;
          w_color = CLEAR_COLOR;
          w_state = S_LOAD;
        end else if (cmd_valid) begin
          w_clear = 1'b0;
          w_x0    = cmd_x0;
          w_y0    = cmd_y0;
          w_x1    = cmd_x1;
          w_y1    = cmd_y1;
          w_color = cmd_color;
          w_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_count = (w_dx >= w_dy) ? w_dx : w_dy;
        w_state = S_DRAW;
      end
      S_DRAW: begin
        if (r_count == 11'd0) begin
          w_state = (r_clear && (r_row != Y_MAX)) ? S_NEXT_ROW : S_DONE;
        end else begin
          w_count = r_count - 11'd1;
        end
      end
      S_NEXT_ROW: begin
        w_row   = r_row + 9'd1;
        w_x0    = '0;
        w_y0    = r_row + 9'd1;
        w_x1    = X_MAX;
        w_y1    = r_row + 9'd1;
        w_state = S_LOAD;
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Control outputs decode the state register directly so reset acts at once.
  assign cmd_ready = (r_state == S_IDLE) && !clear_req;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pix_we    = (r_state == S_DRAW);
  assign drv_reset = (r_state != S_DRAW);

  assign drv_x0    = r_x0;
  assign drv_x1    = r_x1;
  assign drv_y0    = r_y0;
  assign drv_y1    = r_y1;

  // The drawer already presents the pixel being written this cycle.
  assign pix_x     = drv_x;
  assign pix_y     = drv_y;
  assign pix_color = r_color;

endmodule

// File: tb/tb_line_draw_controller.sv
// Bench for line_draw_controller: models the Bresenham drawer, issues directed
// and random line commands plus clears, and checks every framebuffer write
// (position, color, exact cycle) and every done pulse via a scoreboard.
module tb_line_draw_controller;

  localparam int unsigned SW = 16;
  localparam int unsigned SH = 4;
  localparam logic [1:0]  CLR_C = 2'd2;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } pt_t;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] c;
    int         cyc;
    bit         last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [8:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [1:0] cmd_color = '0;
  logic       clear_req = 1'b0;
  logic       busy, done, drv_reset, pix_we;
  logic [9:0] drv_x0, drv_x1, drv_x, pix_x;
  logic [8:0] drv_y0, drv_y1, drv_y, pix_y;
  logic [1:0] pix_color;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  int   exp_ready = 0;

  line_draw_controller #(
    .SCREEN_W(SW), .SCREEN_H(SH), .COLOR_W(2), .CLEAR_COLOR(CLR_C)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .clear_req(clear_req),
    .busy(busy), .done(done), .drv_reset(drv_reset),
    .drv_x0(drv_x0), .drv_x1(drv_x1), .drv_y0(drv_y0), .drv_y1(drv_y1),
    .drv_x(drv_x), .drv_y(drv_y),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Ordered pixel list of a line as the drawer produces it.
  function automatic void line_pts(input int ax0, input int ay0, input int ax1,
                                   input int ay1, output pt_t q[$]);
    int  t, dx, dy, err, ys, y;
    bit  steep;
    pt_t p;
    q = {};
    steep = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (steep) begin
      t = ax0; ax0 = ay0; ay0 = t;
      t = ax1; ax1 = ay1; ay1 = t;
    end
    if (ax0 > ax1) begin
      t = ax0; ax0 = ax1; ax1 = t;
      t = ay0; ay0 = ay1; ay1 = t;
    end
    dx  = ax1 - ax0;
    dy  = iabs(ay1 - ay0);
    err = dx / 2;
    ys  = (ay0 < ay1) ? 1 : -1;
    y   = ay0;
    for (int x = ax0; x <= ax1; x++) begin
      if (steep) begin p.x = 10'(y); p.y = 9'(x); end
      else       begin p.x = 10'(x); p.y = 9'(y); end
      q.push_back(p);
      err = err - dy;
      if (err < 0) begin
        y   = y + ys;
        err = err + dx;
      end
    end
  endfunction

  function automatic pt_t pt_at(input int x0, input int y0, input int x1,
                                input int y1, input int k);
    pt_t q[$];
    line_pts(x0, y0, x1, y1, q);
    if (k >= q.size()) k = q.size() - 1;
    return q[k];
  endfunction

  // Drawer model: captures endpoints while parked, then one pixel per clock.
  logic [9:0] ex0 = '0, ex1 = '0;
  logic [8:0] ey0 = '0, ey1 = '0;
  int         d_step = 0;
  pt_t        d_p;

  always @(posedge clk) begin
    if (drv_reset) begin
      ex0 <= drv_x0; ey0 <= drv_y0; ex1 <= drv_x1; ey1 <= drv_y1;
      d_step <= 0;
    end else begin
      d_step <= d_step + 1;
    end
  end

  always_comb begin
    d_p = pt_at(int'(ex0), int'(ey0), int'(ex1), int'(ey1), d_step);
  end
  assign drv_x = d_p.x;
  assign drv_y = d_p.y;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Expected writes for a line accepted at edge A: pixel i in cycle A+1+i.
  task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [1:0] c, input int a);
    pt_t  q[$];
    exp_t e;
    line_pts(x0, y0, x1, y1, q);
    foreach (q[i]) begin
      e.x = q[i].x; e.y = q[i].y; e.c = c; e.cyc = a + 1 + i;
      e.last = (i == q.size() - 1);
      sb.push_back(e);
    end
    exp_ready = a + 2 + q.size();
  endtask

  // Clear: SH rows of SW writes, each row costing SW+2 cycles.
  task automatic push_clear(input int a);
    exp_t e;
    for (int r = 0; r < int'(SH); r++) begin
      for (int i = 0; i < int'(SW); i++) begin
        e.x = 10'(i); e.y = 9'(r); e.c = CLR_C;
        e.cyc  = a + 1 + r * (int'(SW) + 2) + i;
        e.last = (r == int'(SH) - 1) && (i == int'(SW) - 1);
        sb.push_back(e);
      end
    end
    exp_ready = a + int'(SH) * (int'(SW) + 2);
  endtask

  // Monitor: pops and compares on every write; checks done timing.
  exp_t m_e;
  bit   done_pend = 0;
  int   done_cyc  = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      done_pend = 0;
    end else begin
      if (pix_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          m_e = sb.pop_front();
          chk("pix_xyc", {11'd0, pix_x, pix_y, pix_color}, {11'd0, m_e.x, m_e.y, m_e.c});
          chk("pix_cycle", 32'(cyc), 32'(m_e.cyc));
          if (m_e.last) begin
            done_pend = 1;
            done_cyc  = m_e.cyc + 1;
          end
        end
      end
      if (done_pend && cyc == done_cyc) begin
        chk("done_pulse", 32'(done), 32'd1);
        done_pend = 0;
      end else if (done) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic drive_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [1:0] c);
    cmd_x0 = 10'(x0); cmd_y0 = 9'(y0); cmd_x1 = 10'(x1); cmd_y1 = 9'(y1);
    cmd_color = c;
    cmd_valid = 1'b1;
  endtask

  // Poll cmd_ready (mid-cycle) with a bound; returns accept edge cycle or -1.
  task automatic wait_accept(output int a);
    int k = 0;
    #1;
    while (!cmd_ready && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      a = -1;
    end else begin
      a = cyc + 1;
    end
  endtask

  task automatic issue_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [1:0] c, output int a);
    @(negedge clk);
    drive_cmd(x0, y0, x1, y1, c);
    wait_accept(a);
    if (a >= 0) push_line(x0, y0, x1, y1, c, a);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    @(negedge clk); #1;
    while (!cmd_ready && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    chk(nm, 32'(cyc), 32'(exp_ready));
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int a, ac, lx0, ly0, lx1, ly1;

    // Reset state.
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(pix_we), 32'd0);
    chk("rst_drv_reset", 32'(drv_reset), 32'd1);
    chk("rst_endpoints", {3'd0, drv_x0, drv_x1, drv_y0, drv_y1}, 32'd0);
    chk("rst_color", 32'(pix_color), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk); #1 reset_n = 1'b1;

    // Directed lines.
    issue_cmd(0, 3, 15, 3, 2'd1, a);  wait_ready("ready_horiz");
    issue_cmd(0, 27, 7, 3, 2'd3, a);  wait_ready("ready_steep");
    issue_cmd(5, 5, 5, 5, 2'd1, a);   wait_ready("ready_degen");
    issue_cmd(0, 0, 15, 15, 2'd2, a); wait_ready("ready_diag");

    // Clear pulse.
    @(negedge clk);
    clear_req = 1'b1;
    #1 chk("ready_low_clear", 32'(cmd_ready), 32'd0);
    ac = cyc + 1;
    push_clear(ac);
    @(posedge clk); #1 clear_req = 1'b0;
    wait_ready("ready_clear");

    // Clear and command together: clear first, command held until after done.
    @(negedge clk);
    clear_req = 1'b1;
    drive_cmd(2, 9, 13, 1, 2'd3);
    #1 chk("prio_ready_low", 32'(cmd_ready), 32'd0);
    ac = cyc + 1;
    push_clear(ac);
    @(posedge clk); #1 clear_req = 1'b0;
    @(negedge clk);
    wait_accept(a);
    chk("prio_accept_cyc", 32'(a), 32'(ac + int'(SH) * (int'(SW) + 2) + 1));
    if (a >= 0) push_line(2, 9, 13, 1, 2'd3, a);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_ready("ready_prio_line");

    // Random lines back to back.
    for (int n = 0; n < 40; n++) begin
      lx0 = $urandom_range(40); ly0 = $urandom_range(30);
      lx1 = $urandom_range(40); ly1 = $urandom_range(30);
      issue_cmd(lx0, ly0, lx1, ly1, 2'($urandom_range(3)), a);
      wait_ready("ready_rand");
    end

    // Reset during the 6th write of a horizontal line.
    issue_cmd(0, 0, 20, 0, 2'd1, a);
    while (cyc < a + 5) @(negedge clk);
    @(posedge clk); #2;
    chk("we_before_reset", 32'(pix_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(pix_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_drv_reset", 32'(drv_reset), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk); #1 reset_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    issue_cmd(3, 2, 9, 11, 2'd2, a); wait_ready("ready_after_rst");

    repeat (5) @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("no_done_pending", 32'(done_pend), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_draw_controller.md
Name: line_draw_controller

Overview:
- Sequences the existing Bresenham line drawer, which advances one pixel per clock.
- Accepts line commands through a valid/ready handshake and drives the drawer's endpoints and its synchronous reset.
- Counts the drawer's pixels and emits a framebuffer write stream (x, y, color, write enable) toward the VGA framebuffer.
- Also supports a full-screen clear, issued as one horizontal line per row through the same drawer.

Parameters:
- SCREEN_W, 640, horizontal resolution in pixels (max 1024).
- SCREEN_H, 480, vertical resolution in rows (max 512).
- COLOR_W, 1, pixel color width.
- CLEAR_COLOR, 0, color written during a clear.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  line command present
- cmd_ready  out  1  controller accepts command this cycle
- cmd_x0, cmd_x1  in  10  endpoint x coordinates
- cmd_y0, cmd_y1  in  9  endpoint y coordinates
- cmd_color  in  COLOR_W  line color
- clear_req  in  1  level; request full-screen clear
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when a line or clear completes
- drv_reset  out  1  drives the drawer's active-high synchronous reset
- drv_x0, drv_x1  out  10  drawer endpoints
- drv_y0, drv_y1  out  9  drawer endpoints
- drv_x  in  10  drawer current x
- drv_y  in  9  drawer current y
- pix_x  out  10  framebuffer write x
- pix_y  out  9  framebuffer write y
- pix_color  out  COLOR_W  framebuffer write color
- pix_we  out  1  framebuffer write enable

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, all endpoint registers 0, count 0, row 0.
  - drv_reset = 1; busy, done, pix_we = 0; pix_color = 0.
  - Effect is immediate, including mid-draw: pix_we drops in the same cycle.
- States: IDLE, LOAD, DRAW, NEXT_ROW, DONE.
- IDLE:
  - drv_reset = 1, which parks the drawer.
  - cmd_ready = !clear_req.
  - If clear_req is high: set clear_mode = 1, row = 0, load endpoints (0,0)-(SCREEN_W-1,0), color = CLEAR_COLOR, go to LOAD.
  - Else, if cmd_valid && cmd_ready: register the command's endpoints and color, clear_mode = 0, go to LOAD.
  - clear_req wins over cmd_valid when both are high.
- LOAD (1 cycle):
  - drv_reset = 1 with the registered endpoints stable, so the drawer captures its start pixel at the end of this cycle.
  - count = max(|x1-x0|, |y1-y0|), computed unsigned at 11 bits, giving N = count+1 pixels.
  - Go to DRAW.
- DRAW:
  - drv_reset = 0, pix_we = 1.
  - pix_x = drv_x and pix_y = drv_y, combinational passthrough; pix_color = registered color.
  - Decrement count each cycle. In the cycle where count == 0 (the last pixel):
    - If clear_mode and row == SCREEN_H-1, go to DONE.
    - Else if clear_mode, go to NEXT_ROW.
    - Else go to DONE.
- NEXT_ROW (1 cycle):
  - row += 1; endpoints become (0,row)-(SCREEN_W-1,row).
  - drv_reset = 1, pix_we = 0.
  - Go to LOAD.
- DONE (1 cycle): done = 1, drv_reset = 1, pix_we = 0; go to IDLE.
- Endpoint registers drive drv_x0..drv_y1 directly and never change outside IDLE and NEXT_ROW.
- Latency:
  - Command accepted at edge T.
  - First pix_we in cycle T+2 (LOAD occupies T+1).
  - N consecutive pix_we cycles, then done in the following cycle.
  - cmd_ready again the cycle after done.
  - Per line: N+3 cycles accept-to-ready.
- Degenerate line (x0==x1 && y0==y1): N = 1, exactly one write.
- Pixel order follows the drawer:
  - Non-steep lines (|dy| ≤ |dx|) start from the smaller x.
  - Steep lines start from the smaller y.
- Clear: SCREEN_H rows × SCREEN_W writes, each row costing SCREEN_W+2 cycles; a single done at the end.
- clear_req sampled while busy is ignored; it must still be high in IDLE to start a clear.
- cmd_valid while busy is not accepted; the command is held by the requester.

Test Plan:
- Horizontal line: (0,3)-(15,3), color 1 → one LOAD cycle, then 16 consecutive pix_we with x = 0..15, y = 3, color 1; done 1 cycle after x = 15; cmd_ready high the next cycle.
- Steep negative line: (0,27)-(7,3) → 25 writes; first (7,3), last (0,27); y increments by 1 every write; x monotonically non-increasing.
- Degenerate and diagonal lines: (5,5)-(5,5) → exactly 1 write at (5,5) then done; (0,0)-(15,15) → 16 writes (i,i).
- Clear with SCREEN_W=16, SCREEN_H=4: clear_req pulse → 64 writes in 4 bursts of 16, y = 0..3, color CLEAR_COLOR; 1 gap cycle for NEXT_ROW plus 1 for LOAD between bursts; single done after (15,3).
- Priority: clear_req and cmd_valid both high in IDLE → clear runs first with cmd_ready = 0; the held command is accepted the cycle after done and its line is drawn correctly.
- Reset mid-draw: reset_n low during the 6th write of (0,0)-(20,0) → pix_we, busy = 0 asynchronously and drv_reset = 1; no done pulse; after release cmd_ready = 1 and a new line draws from its start pixel.
